// File: rtl/alu_pkg.sv
// Shared definitions for the ALU-sharing arbiter: op codes, flag bit positions, FSM states.
package alu_pkg;

  localparam int unsigned ADD    = 0;
  localparam int unsigned SUB    = 1;
  localparam int unsigned SL     = 2;
  localparam int unsigned SR     = 3;
  localparam int unsigned AND    = 4;
  localparam int unsigned OR     = 5;
  localparam int unsigned XOR    = 6;
  localparam int unsigned NAND   = 7;
  localparam int unsigned NOT    = 8;
  localparam int unsigned NOR    = 9;
  localparam int unsigned OP_MAX = 9;

  localparam int unsigned FLAG_W  = 5;
  localparam int unsigned FLAG_ZF = 4;
  localparam int unsigned FLAG_NF = 3;
  localparam int unsigned FLAG_EF = 2;
  localparam int unsigned FLAG_GF = 1;
  localparam int unsigned FLAG_LF = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request, ALU and response signals of the ALU-sharing arbiter.
// rsp_err exists only when ALU_OP_CHECK_EN is defined.
interface alu_share_arbiter_if
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned OP_W    = 4
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*OP_W-1:0]   req_op;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [OP_W-1:0]           alu_ctrl;
  logic [DATA_W-1:0]         alu_a;
  logic [DATA_W-1:0]         alu_b;
  logic [DATA_W-1:0]         alu_res;
  logic [FLAG_W-1:0]         alu_flags;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]         rsp_res;
  logic [FLAG_W-1:0]         rsp_flags;
  logic                      busy;
`ifdef ALU_OP_CHECK_EN
  logic                      rsp_err;
`endif

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_res, alu_flags, rsp_ready,
    output req_ready, alu_ctrl, alu_a, alu_b, rsp_valid, rsp_res, rsp_flags, busy
`ifdef ALU_OP_CHECK_EN
    , output rsp_err
`endif
  );

  modport master (
    output req_valid, req_op, req_a, req_b, alu_res, alu_flags, rsp_ready,
    input  req_ready, alu_ctrl, alu_a, alu_b, rsp_valid, rsp_res, rsp_flags, busy
`ifdef ALU_OP_CHECK_EN
    , input rsp_err
`endif
  );

endinterface

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after i_last, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic [IDX_W-1:0] w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_j = IDX_W'((32'(i_last) + k) % NUM_REQ);
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external combinational ALU among NUM_REQ requesters.
// Define ALU_OP_CHECK_EN to reject op codes above OP_MAX with rsp_err instead of forwarding them.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned OP_W    = 4
) (
  input logic            clk,
  input logic            rst,
  alu_share_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  state_e              r_state, w_next;
  logic [IDX_W-1:0]    r_last_gnt, r_gnt_idx, w_pick_idx;
  logic [NUM_REQ-1:0]  r_gnt_oh, w_pick_oh, w_req_ready, w_rsp_valid;
  logic                w_pick_any, w_accept, w_done, w_load;
  logic [OP_W-1:0]     r_alu_ctrl;
  logic [DATA_W-1:0]   r_alu_a, r_alu_b, r_rsp_res;
  logic [FLAG_W-1:0]   r_rsp_flags;
  logic [OP_W-1:0]     w_op [NUM_REQ];
  logic [DATA_W-1:0]   w_a  [NUM_REQ];
  logic [DATA_W-1:0]   w_b  [NUM_REQ];

  // Unpack the per-requester slots
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_op[i] = bus.req_op[i*OP_W +: OP_W];
      w_a[i]  = bus.req_a[i*DATA_W +: DATA_W];
      w_b[i]  = bus.req_b[i*DATA_W +: DATA_W];
    end
  end

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_pick (
    .i_req  (bus.req_valid),
    .i_last (r_last_gnt),
    .o_gnt  (w_pick_oh),
    .o_idx  (w_pick_idx),
    .o_any  (w_pick_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Grant in IDLE is combinational; rst gates it so the accept pulse is low during reset
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_req_ready = '0;
    w_rsp_valid = '0;
    unique case (r_state)
      IDLE: begin
        if (w_pick_any && !rst) begin
          w_accept    = 1'b1;
          w_req_ready = w_pick_oh;
          w_next      = EXEC;
        end
      end
      EXEC: w_next = RESP;
      RESP: begin
        w_rsp_valid = r_gnt_oh;
        if (|(bus.rsp_ready & r_gnt_oh)) begin
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

`ifdef ALU_OP_CHECK_EN
  logic r_op_bad, r_rsp_err, w_sel_bad;
  assign w_sel_bad = (w_op[w_pick_idx] > OP_W'(OP_MAX));
  assign w_load    = w_accept && !w_sel_bad;
`else
  assign w_load    = w_accept;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_gnt  <= IDX_W'(NUM_REQ - 1);
      r_gnt_idx   <= '0;
      r_gnt_oh    <= '0;
      r_alu_ctrl  <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_rsp_res   <= '0;
      r_rsp_flags <= '0;
`ifdef ALU_OP_CHECK_EN
      r_op_bad    <= 1'b0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_gnt_idx <= w_pick_idx;
        r_gnt_oh  <= w_pick_oh;
`ifdef ALU_OP_CHECK_EN
        r_op_bad  <= w_sel_bad;
`endif
      end
      if (w_load) begin
        r_alu_ctrl <= w_op[w_pick_idx];
        r_alu_a    <= w_a[w_pick_idx];
        r_alu_b    <= w_b[w_pick_idx];
      end
      if (r_state == EXEC) begin
        r_rsp_res   <= bus.alu_res;
        r_rsp_flags <= bus.alu_flags;
`ifdef ALU_OP_CHECK_EN
        r_rsp_err   <= r_op_bad;
        if (r_op_bad) begin
          r_rsp_res   <= '0;
          r_rsp_flags <= '0;
        end
`endif
      end
      // Served requester becomes lowest priority for the next round
      if (w_done) r_last_gnt <= r_gnt_idx;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.alu_ctrl  = r_alu_ctrl;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.rsp_res   = r_rsp_res;
  assign bus.rsp_flags = r_rsp_flags;
  assign bus.busy      = (r_state != IDLE);
`ifdef ALU_OP_CHECK_EN
  assign bus.rsp_err   = r_rsp_err;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: behavioural ALU, transaction-level round-robin model, directed + random traffic.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned OW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW)) bus ();

  alu_share_arbiter #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference ALU: result concatenated with {ZF,NF,EF,GF,LF}
  function automatic logic [DW+4:0] alu_fn(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [DW-1:0] r;
    logic [4:0]    f;
    case (32'(op))
      ADD:     r = a + b;
      SUB:     r = a - b;
      SL:      r = a << b[4:0];
      SR:      r = a >> b[4:0];
      AND:     r = a & b;
      OR:      r = a | b;
      XOR:     r = a ^ b;
      NAND:    r = ~(a & b);
      NOT:     r = ~a;
      NOR:     r = ~(a | b);
      default: r = '0;
    endcase
    f[FLAG_ZF] = (r == '0);
    f[FLAG_NF] = r[DW-1];
    f[FLAG_EF] = (a == b);
    f[FLAG_GF] = ($signed(a) > $signed(b));
    f[FLAG_LF] = ($signed(a) < $signed(b));
    return {r, f};
  endfunction

  always_comb {bus.alu_res, bus.alu_flags} = alu_fn(bus.alu_ctrl, bus.alu_a, bus.alu_b);

  // Requester-side state
  logic [N-1:0]  vld;
  logic [OW-1:0] op_q [N];
  logic [DW-1:0] a_q  [N];
  logic [DW-1:0] b_q  [N];

  // Model state
  int            m_last;
  logic [OW-1:0] m_ctrl;
  logic [DW-1:0] m_a, m_b;

  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= int'(N); k++) begin
      int j;
      j = (last + k) % int'(N);
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < int'(N); i++) begin
      bus.req_op[i*OW +: OW] = op_q[i];
      bus.req_a[i*DW +: DW]  = a_q[i];
      bus.req_b[i*DW +: DW]  = b_q[i];
    end
    bus.req_valid = vld;
  endtask

  task automatic set_req(input int i, input logic [OW-1:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b);
    op_q[i] = op; a_q[i] = a; b_q[i] = b;
  endtask

  task automatic check_alu_hold(input string tag);
    check({tag, "_ctrl"}, 64'(bus.alu_ctrl), 64'(m_ctrl));
    check({tag, "_a"},    64'(bus.alu_a),    64'(m_a));
    check({tag, "_b"},    64'(bus.alu_b),    64'(m_b));
  endtask

  // One transaction starting in IDLE, ending back in IDLE one tick after the edge
  task automatic do_txn(input int hold, input logic [N-1:0] late);
    int            g;
    logic [N-1:0]  oh;
    logic [OW-1:0] op;
    logic [DW-1:0] a, b;
    logic          ill;
    logic [DW+4:0] e;
    drive();
    #1;
    g = pick(vld, m_last);
    if (g < 0) begin
      check("idle_ready", 64'(bus.req_ready), 64'(0));
      @(posedge clk); #1;
      check("idle_busy", 64'(bus.busy), 64'(0));
      check_alu_hold("idle");
      return;
    end
    oh = '0; oh[g] = 1'b1;
    check("req_ready", 64'(bus.req_ready), 64'(oh));
    op = op_q[g]; a = a_q[g]; b = b_q[g];
    ill = 1'b0;
`ifdef ALU_OP_CHECK_EN
    ill = (32'(op) > OP_MAX);
`endif
    if (!ill) begin m_ctrl = op; m_a = a; m_b = b; end
    e = ill ? '0 : alu_fn(op, a, b);

    @(posedge clk); #1;
    vld = vld | late;
    drive();
    #1;
    check("exec_busy",  64'(bus.busy),      64'(1));
    check("exec_ready", 64'(bus.req_ready), 64'(0));
    check("exec_rspv",  64'(bus.rsp_valid), 64'(0));
    check_alu_hold("exec");

    @(posedge clk); #1;
    check("rsp_valid", 64'(bus.rsp_valid), 64'(oh));
    check("rsp_res",   64'(bus.rsp_res),   64'(e[DW+4:5]));
    check("rsp_flags", 64'(bus.rsp_flags), 64'(e[4:0]));
`ifdef ALU_OP_CHECK_EN
    check("rsp_err",   64'(bus.rsp_err),   64'(ill));
`endif
    for (int h = 0; h < hold; h++) begin
      bus.rsp_ready = N'($urandom) & ~oh;
      @(posedge clk); #1;
      check("hold_valid", 64'(bus.rsp_valid), 64'(oh));
      check("hold_res",   64'(bus.rsp_res),   64'(e[DW+4:5]));
      check("hold_flags", 64'(bus.rsp_flags), 64'(e[4:0]));
      check("hold_busy",  64'(bus.busy),      64'(1));
      check("hold_ready", 64'(bus.req_ready), 64'(0));
    end
    bus.rsp_ready = N'($urandom) | oh;
    @(posedge clk); #1;
    bus.rsp_ready = '0;
    m_last = g;
    check("done_valid", 64'(bus.rsp_valid), 64'(0));
    check("done_busy",  64'(bus.busy),      64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(bus.req_ready), 64'(0));
    check({tag, "_rspv"},  64'(bus.rsp_valid), 64'(0));
    check({tag, "_res"},   64'(bus.rsp_res),   64'(0));
    check({tag, "_flags"}, 64'(bus.rsp_flags), 64'(0));
    check({tag, "_busy"},  64'(bus.busy),      64'(0));
`ifdef ALU_OP_CHECK_EN
    check({tag, "_err"},   64'(bus.rsp_err),   64'(0));
`endif
    check_alu_hold(tag);
  endtask

  initial begin
    rst = 1'b1;
    vld = '0;
    bus.rsp_ready = '0;
    for (int i = 0; i < int'(N); i++) set_req(i, '0, '0, '0);
    drive();
    m_last = int'(N) - 1;
    m_ctrl = '0; m_a = '0; m_b = '0;
    #3;
    check_reset_outputs("por");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Lone requester 0: 5 + 7
    vld = 4'b0001; set_req(0, 4'd0, 32'd5, 32'd7);
    do_txn(0, '0);
    vld = '0;

    // Everyone requesting, rsp_ready immediate: round-robin rotation
    vld = 4'b1111;
    for (int i = 0; i < int'(N); i++) set_req(i, OW'(i), DW'(i * 3 + 1), DW'(i + 2));
    for (int t = 0; t < 5; t++) do_txn(0, '0);
    vld = '0;

    // Requester 2 subtraction: equal operands, then -1 - 1
    vld = 4'b0100; set_req(2, 4'd1, 32'd3, 32'd3);
    do_txn(0, '0);
    set_req(2, 4'd1, 32'hFFFF_FFFF, 32'd1);
    do_txn(0, '0);
    vld = '0;

    // Requester 1 stalled in RESP while requester 0 waits
    vld = 4'b0010; set_req(1, 4'd6, 32'hA5A5_0F0F, 32'h0FF0_1234); set_req(0, 4'd0, 32'd1, 32'd1);
    do_txn(5, 4'b0001);
    vld = '0;

    // Reset pulsed during EXEC, then first grant after release
    vld = 4'b0100; set_req(2, 4'd5, 32'h1234, 32'h4321);
    drive(); #1;
    @(posedge clk); #1;
    check("pre_rst_busy", 64'(bus.busy), 64'(1));
    #2 rst = 1'b1;
    #1;
    m_ctrl = '0; m_a = '0; m_b = '0; m_last = int'(N) - 1;
    check_reset_outputs("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    vld = 4'b1010; set_req(1, 4'd4, 32'hF0, 32'h3C); set_req(3, 4'd0, 32'd9, 32'd9);
    drive(); #1;
    check("rst_first_gnt", 64'(bus.req_ready), 64'(4'b0010));
    do_txn(0, '0);
    vld = '0;

    // Out-of-range op code, then a legal AND
    vld = 4'b0001; set_req(0, 4'd12, 32'd77, 32'd5);
    do_txn(0, '0);
    set_req(0, 4'd4, 32'd12, 32'd10);
    do_txn(1, '0);
    vld = '0;

    // Random traffic
    for (int t = 0; t < 150; t++) begin
      vld = N'($urandom);
      for (int i = 0; i < int'(N); i++) begin
        logic [DW-1:0] a, b;
        a = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 40)) : DW'($urandom);
        b = ($urandom_range(0, 3) == 0) ? a : DW'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 40));
        set_req(i, OW'($urandom_range(0, 15)), a, b);
      end
      do_txn(int'($urandom_range(0, 3)), N'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
